// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : shared VGA frame constants, fill FSM states, pixel word packing
// Rev 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int VGA_W = 160;
  localparam int VGA_H = 120;
  localparam logic [3:0] PIXEL_ADDR = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_t;

  // Same field layout that vga_avalon decodes: {y, x, 8'h00, colour}
  function automatic logic [31:0] pack_pixel(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic [7:0] colour);
    return {y, x, 8'h00, colour};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rect_fill_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rect_fill_master_if : Avalon-MM write port between a pixel master and slave
// Rev 1.0
// ---------------------------------------------------------------------------
interface rect_fill_master_if;
  logic [3:0]  master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_writedata,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_writedata,
    output master_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/rect_fill_master_raster_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// raster_counter : row-major x/y scan over an inclusive [x0..x1]x[y0..y1] box
// Rev 1.0
// ---------------------------------------------------------------------------
module raster_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic       advance,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last
);
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [7:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (load) begin
      x_d  = x0;
      y_d  = y0;
      x0_d = x0;
      x1_d = x1;
      y1_d = y1;
    end else if (advance) begin
      if (x_q < x1_q) begin
        x_d = x_q + 8'd1;
      end else if (y_q < y1_q) begin
        x_d = x0_q;
        y_d = y_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= 8'd0;
      y_q  <= 8'd0;
      x0_q <= 8'd0;
      x1_q <= 8'd0;
      y1_q <= 8'd0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == x1_q) && (y_q == y1_q);
endmodule
`default_nettype wire

// File: rtl/rect_fill_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rect_fill_master : Avalon-MM master painting a clamped filled rectangle
// Rev 1.0
// ---------------------------------------------------------------------------
module rect_fill_master
  import vga_pkg::*;
#(
  parameter int VGA_W = vga_pkg::VGA_W,
  parameter int VGA_H = vga_pkg::VGA_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            x0,
  input  logic [7:0]            y0,
  input  logic [7:0]            x1,
  input  logic [7:0]            y1,
  input  logic [7:0]            colour,
  output logic                  done,
  output logic                  busy,
  rect_fill_master_if.master    av
);
  localparam logic [7:0] X_MAX = 8'(VGA_W - 1);
  localparam logic [7:0] Y_MAX = 8'(VGA_H - 1);

  fill_state_t state_q, state_d;
  logic [7:0]  colour_q, colour_d;
  logic [7:0]  x1c, y1c, cur_x, cur_y;
  logic        load, empty, accept, last, advance;

  assign x1c     = (x1 > X_MAX) ? X_MAX : x1;
  assign y1c     = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty   = (x0 > x1c) || (y0 > y1c);
  assign load    = (state_q == ST_IDLE) && start;
  assign accept  = (state_q == ST_WRITE) && !av.master_waitrequest;
  assign advance = accept && !last;

  raster_counter u_raster (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1c),
    .y1      (y1c),
    .advance (advance),
    .x       (cur_x),
    .y       (cur_y),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      colour_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          colour_d = colour;
          state_d  = empty ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept && last) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Level-sensitive start: must drop before another fill can begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy                = (state_q == ST_WRITE);
    done                = (state_q == ST_DONE);
    av.master_address   = PIXEL_ADDR;
    av.master_write     = (state_q == ST_WRITE);
    av.master_writedata = (state_q == ST_WRITE) ? pack_pixel(cur_x, cur_y, colour_q)
                                                : 32'd0;
  end
endmodule
`default_nettype wire

// File: tb/tb_rect_fill_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rect_fill_master : directed self-checking bench for rect_fill_master
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rect_fill_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x0, y0, x1, y1, colour;
  logic       done, busy;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_words [0:7];

  rect_fill_master_if av_if ();

  rect_fill_master dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x0     (x0),
    .y0     (y0),
    .x1     (x1),
    .y1     (y1),
    .colour (colour),
    .done   (done),
    .busy   (busy),
    .av     (av_if.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Walk n expected words; pixel stall_at sees stall_n extra waitrequest cycles.
  task automatic expect_fill(input int n, input int stall_at, input int stall_n);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        av_if.master_waitrequest = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_wdata", av_if.master_writedata, exp_words[i]);
          chk("stall_write", {31'd0, av_if.master_write}, 32'd1);
          step();
        end
        av_if.master_waitrequest = 1'b0;
      end
      chk("wdata", av_if.master_writedata, exp_words[i]);
      chk("write", {31'd0, av_if.master_write}, 32'd1);
      chk("busy_in_write", {30'd0, busy, done}, 32'd2);
      chk("addr", {28'd0, av_if.master_address}, 32'd0);
      step();
    end
    chk("done_after_fill", {30'd0, busy, done}, 32'd1);
    chk("write_after_fill", {31'd0, av_if.master_write}, 32'd0);
  endtask

  task automatic set_rect(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input logic [7:0] col);
    x0 = a; y0 = b; x1 = c; y1 = d; colour = col;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; av_if.master_waitrequest = 1'b0;
    set_rect(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step(); step();
    chk("rst_write", {31'd0, av_if.master_write}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_wdata", av_if.master_writedata, 32'd0);
    chk("rst_addr", {28'd0, av_if.master_address}, 32'd0);
    rst = 1'b0;
    step();

    // Basic 3x2 fill, no stalls
    exp_words[0] = 32'h0302001C; exp_words[1] = 32'h0303001C;
    exp_words[2] = 32'h0304001C; exp_words[3] = 32'h0402001C;
    exp_words[4] = 32'h0403001C; exp_words[5] = 32'h0404001C;
    set_rect(8'd2, 8'd3, 8'd4, 8'd4, 8'h1C);
    start = 1'b1;
    step();
    expect_fill(6, -1, 0);
    // start held: no re-trigger
    step(); step();
    chk("hold_no_retrigger", {30'd0, busy, done}, 32'd1);
    chk("hold_no_write", {31'd0, av_if.master_write}, 32'd0);
    start = 1'b0;
    step();
    chk("back_to_idle", {30'd0, busy, done}, 32'd0);

    // Same rectangle with two wait cycles on the third pixel
    start = 1'b1;
    step();
    expect_fill(6, 2, 2);
    start = 1'b0;
    step();

    // Clamped corner
    exp_words[0] = 32'h769E00FF; exp_words[1] = 32'h769F00FF;
    exp_words[2] = 32'h779E00FF; exp_words[3] = 32'h779F00FF;
    set_rect(8'd158, 8'd118, 8'd200, 8'd200, 8'hFF);
    start = 1'b1;
    step();
    expect_fill(4, -1, 0);
    start = 1'b0;
    step();

    // Off-screen and inverted rectangles: straight to DONE
    set_rect(8'd170, 8'd10, 8'd200, 8'd20, 8'h11);
    start = 1'b1;
    step();
    chk("offscreen_done", {30'd0, busy, done}, 32'd1);
    chk("offscreen_nowrite", {31'd0, av_if.master_write}, 32'd0);
    start = 1'b0;
    step();
    chk("offscreen_idle", {30'd0, busy, done}, 32'd0);
    set_rect(8'd5, 8'd10, 8'd3, 8'd20, 8'h22);
    start = 1'b1;
    step();
    chk("inverted_done", {30'd0, busy, done}, 32'd1);
    chk("inverted_nowrite", {31'd0, av_if.master_write}, 32'd0);
    start = 1'b0;
    step();
    chk("inverted_idle", {30'd0, busy, done}, 32'd0);

    // Reset during the third pixel of a 10x10 fill
    set_rect(8'd0, 8'd0, 8'd9, 8'd9, 8'h55);
    start = 1'b1;
    step(); step(); step();
    chk("pre_rst_wdata", av_if.master_writedata, 32'h00020055);
    rst = 1'b1; start = 1'b0;
    step();
    chk("midrst_write", {31'd0, av_if.master_write}, 32'd0);
    chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("midrst_wdata", av_if.master_writedata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_nowrite", {31'd0, av_if.master_write}, 32'd0);
    end

    // New fill after reset; corner inputs change mid-fill and must be ignored
    exp_words[0] = 32'h140A0003; exp_words[1] = 32'h140B0003;
    exp_words[2] = 32'h150A0003; exp_words[3] = 32'h150B0003;
    set_rect(8'd10, 8'd20, 8'd11, 8'd21, 8'h03);
    start = 1'b1;
    step();
    set_rect(8'd0, 8'd0, 8'd50, 8'd50, 8'hAA);
    expect_fill(4, -1, 0);
    start = 1'b0;
    step();
    chk("final_idle", {30'd0, busy, done}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rect_fill_master.md
# rect_fill_master

Avalon-MM master that paints a filled axis-aligned rectangle by issuing one pixel write per coordinate to the VGA pixel slave, the write-side counterpart of `vga_avalon`. It clamps the requested rectangle to the 160×120 frame, scans it in row-major order, and honours `waitrequest` on every transfer. It sits between a start/done controller (or the Nios/HPS) and the VGA slave's Avalon port.

## Interface
- `VGA_W`, 160, frame width in pixels
- `VGA_H`, 120, frame height in pixels
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  level request; sampled in IDLE and DONE
- `x0`, `y0`  in  8 each  top-left corner, inclusive
- `x1`, `y1`  in  8 each  bottom-right corner, inclusive
- `colour`  in  8  fill colour
- `done`  out  1  rectangle complete; held until `start` drops
- `busy`  out  1  high while in WRITE
- `master_address`  out  4  word address; always 0 (pixel register)
- `master_write`  out  1  Avalon write request
- `master_writedata`  out  32  `{y[7:0], x[7:0], 8'h00, colour[7:0]}`
- `master_waitrequest`  in  1  slave stall

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: on `start`=1, latch `colour`, `x0`, `y0`; latch `x1c = min(x1, VGA_W-1)`, `y1c = min(y1, VGA_H-1)`; set `x=x0`, `y=y0`. If `x0>x1c` or `y0>y1c` (empty or fully off-screen) go directly to DONE; otherwise go to WRITE.
- WRITE: `master_write`=1 with writedata packed from current `x`, `y`, latched colour. A transfer is accepted on a rising edge where `master_write`=1 and `master_waitrequest`=0. On acceptance: if `x<x1c`, `x++`; else if `y<y1c`, `x=x0`, `y++`; else go to DONE. Without acceptance, address/writedata/write stay stable.
- DONE: `done`=1, `master_write`=0. When `start`=0, go to IDLE. While `start` stays 1, remain in DONE (no re-trigger).
- Inputs `x0..y1`, `colour` are ignored outside IDLE; changes mid-fill do not affect the current rectangle.
- Counters are 8-bit; clamping guarantees no wrap (max x 159, max y 119).
- Bits 15:8 of writedata are always 0. `master_address` is constant 0.

## Timing
- Reset values: state IDLE, `done`=0, `busy`=0, `master_write`=0, `master_writedata`=0, `master_address`=0.
- `start` sampled high at edge N → `master_write`=1 during cycle N+1 (first pixel `(x0,y0)`).
- With `waitrequest` held 0: one pixel per cycle; N pixels take N cycles; `done`=1 in the cycle after the last acceptance.
- Each `waitrequest`=1 cycle adds exactly one cycle; pixel order is unchanged.
- Empty rectangle: `done`=1 in cycle N+1, zero writes issued.
- `rst` asserted mid-fill: at that edge all outputs take reset values; no further writes; no resume after release.
- `busy` equals (state == WRITE); `busy` and `done` are never both 1.
- All outputs are registered (driven from state/counter flops), no combinational path from `master_waitrequest` to outputs other than through the next edge.

## Structure
- Package `vga_pkg`: `VGA_W`/`VGA_H` defaults, `PIXEL_ADDR` (4'd0), state enum `fill_state_t`, function `pack_pixel(x, y, colour)` returning the 32-bit word. Share `pack_pixel` with `vga_avalon`'s field decode.
- One natural sub-module: `raster_counter` (x/y bounds, `advance` input, `last` output), reused later by line/circle masters.

## Test plan
- Rectangle (2,3)-(4,4), colour 8'h1C, waitrequest 0 → 6 writes in order 32'h0302001C, 32'h0303001C, 32'h0304001C, 32'h0402001C, 32'h0403001C, 32'h0404001C; `done` in the 7th cycle after start.
- Same rectangle, waitrequest high 2 cycles on the 3rd pixel → writedata 32'h0304001C held stable 3 cycles, same 6-word sequence, `done` 2 cycles later.
- (158,118)-(200,200), colour 8'hFF → clamped to 159/119; exactly 4 writes: (158,118),(159,118),(158,119),(159,119).
- x0=170 or x0=5,x1=3 → no `master_write`, `done`=1 one cycle after start; drop `start` → IDLE, `done`=0 next cycle.
- `rst`=1 during the 3rd pixel of a 10×10 fill → `master_write`=0, `done`=0, `busy`=0 after that edge; no writes after release until a new `start`.
- Hold `start` high through DONE → no second fill; toggle low then high → second fill starts from its own latched corners.
